// File: rtl/mem_port_if.sv
// Bundle of the L2 read port, the eviction-write-buffer drain port and the
// wishbone port towards physical memory.
//
// Handshakes: rd_req / wb_req are level requests held by the requester until
// the matching one-cycle rd_ack / wb_ack pulse. On the memory side, CYC/STB
// stay high for the whole transaction. The transaction ends in the cycle
// where mem_ack is high. rd_dat is valid while rd_ack is high.
//
// master: the arbiter (owns the memory port).
// slave : the environment (L2, EWB and physical memory).
interface mem_port_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 256
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_adr;
  logic [DATA_W-1:0] rd_dat;
  logic              rd_ack;
  logic              wb_req;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_dat;
  logic              wb_ack;
  logic              mem_cyc;
  logic              mem_stb;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_dat_m;
  logic [DATA_W/8-1:0] mem_sel;
  logic [DATA_W-1:0] mem_dat_s;
  logic              mem_ack;

  modport master (
    input  rd_req, rd_adr, wb_req, wb_adr, wb_dat, mem_dat_s, mem_ack,
    output rd_dat, rd_ack, wb_ack, mem_cyc, mem_stb, mem_we, mem_adr,
           mem_dat_m, mem_sel
  );

  modport slave (
    output rd_req, rd_adr, wb_req, wb_adr, wb_dat, mem_dat_s, mem_ack,
    input  rd_dat, rd_ack, wb_ack, mem_cyc, mem_stb, mem_we, mem_adr,
           mem_dat_m, mem_sel
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one wishbone port between L2 miss reads and
// eviction-write-buffer drains, one line transaction at a time. Reads are
// preferred. A waiting write is forced after WR_STARVE_MAX reads. A read
// that hits the buffered write line (RAW) is ordered behind the write.
// Optional macro MEMPORT_RAW_FWD_EN: a RAW read is served directly from
// wb_dat in a FWD state, with no memory access.
module mem_port_arbiter #(
  parameter int ADDR_W        = 27,
  parameter int DATA_W        = 256,
  parameter int WR_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_port_if.master  bus,
  output logic [1:0]  state_dbg,
  output logic [7:0]  starve_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
`ifdef MEMPORT_RAW_FWD_EN
  localparam logic [1:0] FWD  = 2'd3;
`endif
  localparam logic [7:0] STARVE_MAX = 8'(WR_STARVE_MAX);

  logic [1:0]        state, state_d;
  logic [7:0]        starve_cnt, starve_d;
  logic [ADDR_W-1:0] mem_adr_q;
  logic [DATA_W-1:0] mem_dat_m_q;
  logic [DATA_W-1:0] rd_dat_q;
  logic [DATA_W-1:0] rd_dat_c;
  logic              rd_ack_c;
  logic              busy;
  logic              raw;

  assign raw  = (bus.rd_adr == bus.wb_adr);
  assign busy = (state == RD) || (state == WR);

  // Grant decision in IDLE, completion tracking in RD/WR.
  always_comb begin
    state_d  = state;
    starve_d = starve_cnt;
    case (state)
      IDLE: begin
        if (bus.rd_req && bus.wb_req) begin
          if (raw) begin
`ifdef MEMPORT_RAW_FWD_EN
            state_d = FWD;
`else
            state_d  = WR;
            starve_d = 8'd0;
`endif
          end else if (starve_cnt < STARVE_MAX) begin
            state_d  = RD;
            starve_d = starve_cnt + 8'd1;
          end else begin
            state_d  = WR;
            starve_d = 8'd0;
          end
        end else if (bus.rd_req) begin
          state_d = RD;
        end else if (bus.wb_req) begin
          state_d  = WR;
          starve_d = 8'd0;
        end
      end
      RD, WR: begin
        if (bus.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read completion: data passes straight through in the ack cycle.
  always_comb begin
    rd_ack_c = 1'b0;
    rd_dat_c = rd_dat_q;
    if (state == RD && bus.mem_ack) begin
      rd_ack_c = 1'b1;
      rd_dat_c = bus.mem_dat_s;
    end
`ifdef MEMPORT_RAW_FWD_EN
    if (state == FWD) begin
      rd_ack_c = 1'b1;
      rd_dat_c = bus.wb_dat;
    end
`endif
  end

  // FSM, starvation counter, latched transaction and held read line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= 8'd0;
      mem_adr_q   <= '0;
      mem_dat_m_q <= '0;
      rd_dat_q    <= '0;
    end else begin
      state      <= state_d;
      starve_cnt <= starve_d;
      if (state == IDLE && state_d == RD) begin
        mem_adr_q <= bus.rd_adr;
      end
      if (state == IDLE && state_d == WR) begin
        mem_adr_q   <= bus.wb_adr;
        mem_dat_m_q <= bus.wb_dat;
      end
      if (rd_ack_c) begin
        rd_dat_q <= rd_dat_c;
      end
    end
  end

  assign bus.mem_cyc   = busy;
  assign bus.mem_stb   = busy;
  assign bus.mem_we    = (state == WR);
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_dat_m = mem_dat_m_q;
  assign bus.mem_sel   = busy ? {(DATA_W/8){1'b1}} : {(DATA_W/8){1'b0}};
  assign bus.rd_ack    = rd_ack_c;
  assign bus.rd_dat    = rd_dat_c;
  assign bus.wb_ack    = (state == WR) && bus.mem_ack;

  assign state_dbg  = state;
  assign starve_dbg = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory responder.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 256;
  localparam int SEL_W  = DATA_W / 8;
  localparam logic [DATA_W-1:0] A5_LINE = {32{8'hA5}};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  logic [7:0] starve_dbg;

  int total = 0;
  int bad   = 0;

  int ack_delay = 1;
  bit resp_en   = 1'b0;
  bit force_ack = 1'b0;
  int resp_cnt  = 0;

  mem_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.master),
    .state_dbg  (state_dbg),
    .starve_dbg (starve_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
    if (a == 27'h123) return A5_LINE;
    return {8{5'b0, a}};
  endfunction

  // Memory model: acks after ack_delay STB cycles, returns mem_line(adr).
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_dat_s = '0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        bus.mem_ack = force_ack;
        resp_cnt    = 0;
      end else if (rst || bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        resp_cnt    = 0;
      end else if (bus.mem_stb) begin
        resp_cnt++;
        if (resp_cnt >= ack_delay) begin
          bus.mem_dat_s = mem_line(bus.mem_adr);
          bus.mem_ack   = 1'b1;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    total++;
    if (state_dbg !== 2'd0 || starve_dbg !== 8'd0 || bus.mem_cyc !== 1'b0 ||
        bus.mem_stb !== 1'b0 || bus.rd_ack !== 1'b0 || bus.wb_ack !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl state=%0d starve=%0d cyc=%b stb=%b rd_ack=%b wb_ack=%b want all 0",
               state_dbg, starve_dbg, bus.mem_cyc, bus.mem_stb, bus.rd_ack, bus.wb_ack);
    end
    total++;
    if (bus.rd_dat !== '0 || bus.mem_adr !== '0 || bus.mem_dat_m !== '0 || bus.mem_sel !== '0) begin
      bad++;
      $display("FAIL reset_data rd_dat=%h mem_adr=%h sel=%h want 0", bus.rd_dat, bus.mem_adr, bus.mem_sel);
    end
    rst = 1'b0;
    resp_en = 1'b0;
    bus.rd_adr = 27'h55;
    bus.rd_req = 1'b1;
    tick();
    total++;
    if (bus.mem_stb !== 1'b1 || bus.mem_adr !== 27'h55) begin
      bad++;
      $display("FAIL reset_pre_rd stb=%b adr=%h want stb=1 adr=55", bus.mem_stb, bus.mem_adr);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.mem_cyc !== 1'b0 || bus.rd_ack !== 1'b0 || state_dbg !== 2'd0 ||
        starve_dbg !== 8'd0 || bus.mem_adr !== '0) begin
      bad++;
      $display("FAIL reset_mid_rd cyc=%b rd_ack=%b state=%0d starve=%0d adr=%h want 0",
               bus.mem_cyc, bus.rd_ack, state_dbg, starve_dbg, bus.mem_adr);
    end
    bus.rd_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lone_read();
    bit seen_stb = 1'b0;
    bit got      = 1'b0;
    ack_delay = 3;
    resp_en   = 1'b1;
    bus.rd_adr = 27'h123;
    bus.rd_req = 1'b1;
    for (int t = 1; t <= 20 && !got; t++) begin
      tick();
      if (bus.mem_stb && !seen_stb) begin
        seen_stb = 1'b1;
        total++;
        if (bus.mem_we !== 1'b0 || bus.mem_sel !== {SEL_W{1'b1}} || t != 1) begin
          bad++;
          $display("FAIL lone_read_ctl we=%b sel=%h cycle=%0d want we=0 sel=all ones cycle=1",
                   bus.mem_we, bus.mem_sel, t);
        end
      end
      if (bus.rd_ack) begin
        got = 1'b1;
        bus.rd_req = 1'b0;
        total++;
        if (t != 3 || bus.rd_dat !== A5_LINE) begin
          bad++;
          $display("FAIL lone_read_ack cycle=%0d rd_dat=%h want cycle=3 rd_dat=a5..", t, bus.rd_dat);
        end
      end
    end
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL lone_read_timeout got=%b want 1", got);
    end
    tick();
    total++;
    if (bus.rd_ack !== 1'b0 || bus.mem_cyc !== 1'b0 || bus.rd_dat !== A5_LINE) begin
      bad++;
      $display("FAIL lone_read_after rd_ack=%b cyc=%b rd_dat=%h want 0 0 a5..",
               bus.rd_ack, bus.mem_cyc, bus.rd_dat);
    end
  endtask

  task automatic test_abandon();
    bit got = 1'b0;
    ack_delay = 3;
    resp_en   = 1'b1;
    bus.rd_adr = 27'h9;
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      tick();
      if (bus.rd_ack) begin
        got = 1'b1;
        total++;
        if (bus.rd_dat !== mem_line(27'h9)) begin
          bad++;
          $display("FAIL abandon_data rd_dat=%h want %h", bus.rd_dat, mem_line(27'h9));
        end
      end
    end
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL abandon_ack got=%b want 1", got);
    end
    tick();
  endtask

  task automatic test_idle_ack();
    resp_en   = 1'b0;
    force_ack = 1'b1;
    tick();
    total++;
    if (bus.rd_ack !== 1'b0 || bus.wb_ack !== 1'b0 || state_dbg !== 2'd0 || bus.mem_cyc !== 1'b0) begin
      bad++;
      $display("FAIL idle_ack rd_ack=%b wb_ack=%b state=%0d cyc=%b want 0",
               bus.rd_ack, bus.wb_ack, state_dbg, bus.mem_cyc);
    end
    force_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_starvation();
    logic [DATA_W-1:0] wline = {8{32'hDEAD_0040}};
    int reads = 0;
    bit wdone = 1'b0;
    ack_delay = 1;
    resp_en   = 1'b1;
    bus.wb_adr = 27'h40;
    bus.wb_dat = wline;
    bus.wb_req = 1'b1;
    bus.rd_adr = 27'h100;
    bus.rd_req = 1'b1;
    for (int t = 0; t < 60 && !wdone; t++) begin
      tick();
      total++;
      if ((bus.rd_ack & bus.wb_ack) !== 1'b0) begin
        bad++;
        $display("FAIL starve_overlap rd_ack=%b wb_ack=%b want not both", bus.rd_ack, bus.wb_ack);
      end
      if (bus.rd_ack) begin
        reads++;
        total++;
        if (bus.rd_dat !== mem_line(bus.rd_adr)) begin
          bad++;
          $display("FAIL starve_rd_data rd_dat=%h want %h", bus.rd_dat, mem_line(bus.rd_adr));
        end
        bus.rd_adr = bus.rd_adr + 27'h1;
      end
      if (bus.wb_ack) begin
        wdone = 1'b1;
        total++;
        if (reads != 4) begin
          bad++;
          $display("FAIL starve_reads reads=%0d want 4", reads);
        end
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_adr !== 27'h40 || bus.mem_dat_m !== wline ||
            starve_dbg !== 8'd0) begin
          bad++;
          $display("FAIL starve_write we=%b adr=%h starve=%0d want we=1 adr=40 starve=0",
                   bus.mem_we, bus.mem_adr, starve_dbg);
        end
        bus.wb_req = 1'b0;
        bus.rd_req = 1'b0;
      end
    end
    total++;
    if (wdone !== 1'b1) begin
      bad++;
      $display("FAIL starve_timeout wdone=%b want 1", wdone);
    end
    tick();
    tick();
  endtask

  task automatic test_raw();
    logic [DATA_W-1:0] wline = {8{32'h7777_BEEF}};
    bit rd_done = 1'b0;
    bit wb_done = 1'b0;
    bit rd_stb  = 1'b0;
    int first_we = -1;
    ack_delay = 2;
    resp_en   = 1'b1;
    bus.rd_adr = 27'h77;
    bus.wb_adr = 27'h77;
    bus.wb_dat = wline;
    bus.rd_req = 1'b1;
    bus.wb_req = 1'b1;
    for (int t = 1; t <= 40 && !(rd_done && wb_done); t++) begin
      tick();
      if (bus.mem_stb && first_we < 0) first_we = int'(bus.mem_we);
      if (bus.mem_stb && !bus.mem_we) rd_stb = 1'b1;
      total++;
      if ((bus.rd_ack & bus.wb_ack) !== 1'b0) begin
        bad++;
        $display("FAIL raw_overlap rd_ack=%b wb_ack=%b want not both", bus.rd_ack, bus.wb_ack);
      end
      if (bus.wb_ack) begin
        wb_done = 1'b1;
        bus.wb_req = 1'b0;
      end
      if (bus.rd_ack) begin
        rd_done = 1'b1;
        bus.rd_req = 1'b0;
`ifdef MEMPORT_RAW_FWD_EN
        total++;
        if (t != 1 || bus.rd_dat !== wline || wb_done !== 1'b0) begin
          bad++;
          $display("FAIL raw_fwd cycle=%0d rd_dat=%h wb_done=%b want cycle=1 rd_dat=%h wb_done=0",
                   t, bus.rd_dat, wb_done, wline);
        end
`else
        total++;
        if (wb_done !== 1'b1 || bus.rd_dat !== mem_line(27'h77)) begin
          bad++;
          $display("FAIL raw_order wb_done=%b rd_dat=%h want wb_done=1 rd_dat=%h",
                   wb_done, bus.rd_dat, mem_line(27'h77));
        end
`endif
      end
    end
    total++;
    if (rd_done !== 1'b1 || wb_done !== 1'b1) begin
      bad++;
      $display("FAIL raw_timeout rd_done=%b wb_done=%b want 1 1", rd_done, wb_done);
    end
`ifdef MEMPORT_RAW_FWD_EN
    total++;
    if (rd_stb !== 1'b0) begin
      bad++;
      $display("FAIL raw_fwd_no_mem read_stb=%b want 0", rd_stb);
    end
`else
    total++;
    if (first_we != 1 || rd_stb !== 1'b1) begin
      bad++;
      $display("FAIL raw_wr_first first_we=%0d read_stb=%b want 1 1", first_we, rd_stb);
    end
`endif
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int rd_t = -1;
    int wb_t = -1;
    int low  = 0;
    ack_delay = 1;
    resp_en   = 1'b1;
    bus.rd_adr = 27'h200;
    bus.wb_adr = 27'h300;
    bus.wb_dat = {8{32'h3000_0003}};
    bus.rd_req = 1'b1;
    bus.wb_req = 1'b1;
    for (int t = 1; t <= 20 && (rd_t < 0 || wb_t < 0); t++) begin
      tick();
      total++;
      if ((bus.rd_ack & bus.wb_ack) !== 1'b0) begin
        bad++;
        $display("FAIL b2b_overlap rd_ack=%b wb_ack=%b want not both", bus.rd_ack, bus.wb_ack);
      end
      if (bus.rd_ack) begin
        rd_t = t;
        bus.rd_req = 1'b0;
      end
      if (bus.wb_ack) begin
        wb_t = t;
        bus.wb_req = 1'b0;
      end
      if (rd_t > 0 && wb_t < 0 && bus.mem_cyc === 1'b0) low++;
    end
    total++;
    if (rd_t != 1 || wb_t != 3 || low != 1) begin
      bad++;
      $display("FAIL b2b_timing rd_cycle=%0d wb_cycle=%0d idle_cycles=%0d want 1 3 1", rd_t, wb_t, low);
    end
    tick();
  endtask

  initial begin
    bus.rd_req = 1'b0;
    bus.rd_adr = '0;
    bus.wb_req = 1'b0;
    bus.wb_adr = '0;
    bus.wb_dat = '0;
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_lone_read();
    test_abandon();
    test_idle_ack();
    test_starvation();
    test_raw();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
